seg7_scan_driver: RTL

Time-multiplexed 4-digit 7-segment display driver that sits directly downstream of the multiplier datapath. It latches a 16-bit display word (four hex nibbles) plus per-digit decimal points on a load strobe. It scans the four common-anode digits one at a time, with a programmable on-time and an all-off ghosting gap between digits. Optional leading-zero blanking suppresses unused high digits.

---
 rtl/seg7_pkg.sv | 10 +
 rtl/seg7_hex_decode.sv | 10 +
 rtl/seg7_scan_driver.sv | 81 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scan state, blanking constants and hex glyph table
package seg7_pkg;
  typedef enum logic {ST_ON, ST_GAP} scan_state_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble plus decimal-point request to active-low segments
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);
  assign o_seg = {~i_dp, GLYPH[i_nibble][6:0]};
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment scanner with ghosting gap and zero blanking
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_en,
  output logic [7:0]  segments,
  output logic [3:0]  anodes
);
  localparam int CMAX = REFRESH_DIV > GAP_CYCLES ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW = $clog2(CMAX);
  scan_state_t r_state, w_state_n;
  logic [1:0]    r_idx, w_idx_n, w_nidx;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [15:0]   r_val;
  logic [3:0]    r_dp, r_an, w_an_n;
  logic [7:0]    r_seg, w_seg_n, w_glyph;
  logic          w_blank;
  assign w_nidx = r_idx + 2'd1;
  assign w_blank = blank_en && (w_nidx != 2'd0) && ((r_val >> {w_nidx, 2'b00}) == 16'd0);
  seg7_hex_decode u_dec (
    .i_nibble (r_val[4*w_nidx +: 4]),
    .i_dp     (r_dp[w_nidx]),
    .o_seg    (w_glyph)
  );
  // holding registers capture the display word on the load strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_val <= '0;
      r_dp <= '0;
    end else if (load) begin
      r_val <= value;
      r_dp <= dp_in;
    end
  // scan state, counters and outputs; outputs change only at slot boundaries
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_ON;
      r_idx <= '0;
      r_cnt <= '0;
      r_an <= 4'b1110;
      r_seg <= 8'hC0;
    end else begin
      r_state <= w_state_n;
      r_idx <= w_idx_n;
      r_cnt <= w_cnt_n;
      r_an <= w_an_n;
      r_seg <= w_seg_n;
    end
  // next-state: ON slot ends into an all-off gap, gap end lights the next digit
  always_comb begin
    w_state_n = r_state;
    w_idx_n = r_idx;
    w_cnt_n = r_cnt + 1'b1;
    w_an_n = r_an;
    w_seg_n = r_seg;
    if (r_state == ST_ON) begin
      if (r_cnt == CW'(REFRESH_DIV - 1)) begin
        w_state_n = ST_GAP;
        w_cnt_n = '0;
        w_an_n = AN_OFF;
        w_seg_n = SEG_BLANK;
      end
    end else if (r_cnt == CW'(GAP_CYCLES - 1)) begin
      w_state_n = ST_ON;
      w_cnt_n = '0;
      w_idx_n = w_nidx;
      w_an_n = w_blank ? AN_OFF : ~(4'b0001 << w_nidx);
      w_seg_n = w_blank ? SEG_BLANK : w_glyph;
    end
  end
  assign segments = r_seg;
  assign anodes = r_an;
endmodule
